// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: streaming image-load port plus 1-cycle registered fetch.
// Optional INST_MEM_CHECKSUM_EN adds LoadSum, the modulo-2**W sum of the accepted load beats.
module inst_mem_loadable #(
  parameter int A = 10,
  parameter int W = 9,
  parameter int DEPTH = 2**A,
  parameter logic [W-1:0] HALT_WORD = {W{1'b1}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadReady,
  output logic         LoadDone,
  output logic         Loaded,
  output logic [A:0]   LoadCount,
  input  logic         FetchReq,
  input  logic [A-1:0] FetchAddr,
  output logic         FetchValid,
  output logic [W-1:0] InstOut,
  output logic         FetchErr
`ifdef INST_MEM_CHECKSUM_EN
  ,
  output logic [W-1:0] LoadSum
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);
  localparam logic [A:0] DEPTH_W = (A + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [A:0]      count_q;
  logic            done_q;
  logic            loaded_q;
  logic            fvalid_q;
  logic            ferr_q;
  logic            sel_q;
  logic [W-1:0]    rd_q;
  logic [W-1:0]    mem [0:DEPTH-1];

  logic            beat_d;
  logic            last_beat_d;
  logic            addr_ok_d;
  logic            fetch_ok_d;
  logic [IW-1:0]   rd_idx_d;

  // A LoadStart always wins over a beat presented in the same cycle.
  assign beat_d      = (state_q == S_LOAD) && LoadValid && !LoadStart;
  assign last_beat_d = beat_d && (LoadLast || (ptr_q == LAST_PTR));
  assign addr_ok_d   = ({1'b0, FetchAddr} < DEPTH_W);
  assign fetch_ok_d  = (state_q == S_RUN) && !LoadStart && addr_ok_d;
  assign rd_idx_d    = FetchAddr[IW-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (LoadStart) begin
        state_q  <= S_LOAD;
        ptr_q    <= '0;
        count_q  <= '0;
        loaded_q <= 1'b0;
      end else if (beat_d) begin
        ptr_q <= ptr_q + 1'b1;
        if (count_q != DEPTH_W) begin
          count_q <= count_q + 1'b1;
        end
        if (last_beat_d) begin
          state_q  <= S_RUN;
          loaded_q <= 1'b1;
          done_q   <= 1'b1;
        end
      end
    end
  end

  // Fetch status is reset; the data path below stays reset-free so it maps onto block RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      fvalid_q <= FetchReq;
      ferr_q   <= FetchReq && !fetch_ok_d;
      if (FetchReq) begin
        sel_q <= fetch_ok_d;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (beat_d) begin
      mem[ptr_q] <= LoadData;
    end
    if (FetchReq && fetch_ok_d) begin
      rd_q <= mem[rd_idx_d];
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  logic [W-1:0] sum_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_q <= '0;
    end else if (LoadStart) begin
      sum_q <= '0;
    end else if (beat_d) begin
      sum_q <= sum_q + LoadData;
    end
  end

  assign LoadSum = sum_q;
`endif

  assign LoadReady  = (state_q == S_LOAD);
  assign LoadDone   = done_q;
  assign Loaded     = loaded_q;
  assign LoadCount  = count_q;
  assign FetchValid = fvalid_q;
  assign FetchErr   = ferr_q;
  // A rejected fetch clears sel_q, so InstOut shows HALT_WORD until the next good fetch.
  assign InstOut    = sel_q ? rd_q : HALT_WORD;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench: two instances (DEPTH=6/A=3 and DEPTH=4/A=2) share one random stimulus
// stream and are checked against a behavioural model of the load/fetch rules.
module tb_inst_mem_loadable;

  localparam int W = 9;
  localparam logic [W-1:0] HALT = 9'h1FF;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b1;
  logic         LoadStart = 1'b0;
  logic         LoadValid = 1'b0;
  logic [W-1:0] LoadData = '0;
  logic         LoadLast = 1'b0;
  logic         FetchReq = 1'b0;
  logic [2:0]   FetchAddr = '0;

  logic         ready0, done0, loaded0, fv0, fe0;
  logic         ready1, done1, loaded1, fv1, fe1;
  logic [3:0]   cnt0;
  logic [2:0]   cnt1;
  logic [W-1:0] inst0, inst1;
`ifdef INST_MEM_CHECKSUM_EN
  logic [W-1:0] sum0, sum1;
`endif

  always #5 Clk = ~Clk;

  inst_mem_loadable #(.A(3), .W(W), .DEPTH(6)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(ready0), .LoadDone(done0),
    .Loaded(loaded0), .LoadCount(cnt0), .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .FetchValid(fv0), .InstOut(inst0), .FetchErr(fe0)
`ifdef INST_MEM_CHECKSUM_EN
    , .LoadSum(sum0)
`endif
  );

  inst_mem_loadable #(.A(2), .W(W)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(ready1), .LoadDone(done1),
    .Loaded(loaded1), .LoadCount(cnt1), .FetchReq(FetchReq), .FetchAddr(FetchAddr[1:0]),
    .FetchValid(fv1), .InstOut(inst1), .FetchErr(fe1)
`ifdef INST_MEM_CHECKSUM_EN
    , .LoadSum(sum1)
`endif
  );

  logic         o_ready [2];
  logic         o_done  [2];
  logic         o_loaded[2];
  logic [3:0]   o_cnt   [2];
  logic         o_fv    [2];
  logic         o_fe    [2];
  logic [W-1:0] o_inst  [2];
  assign o_ready[0] = ready0;   assign o_ready[1] = ready1;
  assign o_done[0] = done0;     assign o_done[1] = done1;
  assign o_loaded[0] = loaded0; assign o_loaded[1] = loaded1;
  assign o_cnt[0] = cnt0;       assign o_cnt[1] = {1'b0, cnt1};
  assign o_fv[0] = fv0;         assign o_fv[1] = fv1;
  assign o_fe[0] = fe0;         assign o_fe[1] = fe1;
  assign o_inst[0] = inst0;     assign o_inst[1] = inst1;

  // Reference model: what each memory should be doing, in terms of the load/fetch rules.
  int           m_depth [2] = '{6, 4};
  bit           m_loading[2];
  bit           m_running[2];
  bit           m_loaded [2];
  bit           m_done   [2];
  bit           m_valid  [2];
  int           m_cnt    [2];
  logic [W-1:0] m_sum    [2];
  logic [W-1:0] m_inst   [2];
  logic [W-1:0] img      [2][8];
  logic [W:0]   q0[$];
  logic [W:0]   q1[$];

  int errors = 0;
  int checks = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_loading[i] = 0; m_running[i] = 0; m_loaded[i] = 0; m_done[i] = 0;
        m_valid[i] = 0; m_cnt[i] = 0; m_sum[i] = '0; m_inst[i] = HALT;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int a;
        logic [W:0] e;
        a = (i == 0) ? int'(FetchAddr) : int'(FetchAddr[1:0]);
        m_valid[i] = FetchReq;
        if (FetchReq) begin
          if (m_running[i] && !LoadStart && a < m_depth[i]) e = {1'b0, img[i][a]};
          else e = {1'b1, HALT};
          m_inst[i] = e[W-1:0];
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        m_done[i] = 0;
        if (LoadStart) begin
          m_loading[i] = 1; m_running[i] = 0; m_loaded[i] = 0; m_cnt[i] = 0; m_sum[i] = '0;
        end else if (m_loading[i] && LoadValid) begin
          img[i][m_cnt[i]] = LoadData;
          m_cnt[i] = m_cnt[i] + 1;
          m_sum[i] = m_sum[i] + LoadData;
          if (LoadLast || m_cnt[i] == m_depth[i]) begin
            m_loading[i] = 0; m_running[i] = 1; m_loaded[i] = 1; m_done[i] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got=%0h exp=%0h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // Monitor: runs 1 time unit after each falling clock edge and after reset assertion,
  // so an asynchronous reset is observed before any clock edge has occurred.
  always @(negedge Clk or negedge Reset_n) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [W:0] e;
      chk("load_ready", i, o_ready[i], m_loading[i]);
      chk("load_done", i, o_done[i], m_done[i]);
      chk("loaded", i, o_loaded[i], m_loaded[i]);
      chk("load_count", i, o_cnt[i], m_cnt[i]);
`ifdef INST_MEM_CHECKSUM_EN
      chk("load_sum", i, (i == 0) ? sum0 : sum1, m_sum[i]);
`endif
      if (m_done[i]) $display("load  u%0d done count=%0d", i, m_cnt[i]);
      chk("fetch_valid", i, o_fv[i], m_valid[i]);
      if (m_valid[i]) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          chk("scoreboard_empty", i, 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("fetch_err", i, o_fe[i], e[W]);
          chk("inst_out", i, o_inst[i], e[W-1:0]);
          $display("fetch u%0d err=%0b inst=%h (exp err=%0b inst=%h)",
                   i, o_fe[i], o_inst[i], e[W], e[W-1:0]);
        end
      end else begin
        chk("fetch_err_idle", i, o_fe[i], 0);
        chk("inst_hold", i, o_inst[i], m_inst[i]);
      end
    end
  end

  task automatic cyc(input bit ls, input bit lv, input bit ll, input logic [W-1:0] d,
                     input bit fr, input logic [2:0] fa);
    @(posedge Clk);
    #1;
    LoadStart = ls; LoadValid = lv; LoadLast = ll; LoadData = d;
    FetchReq = fr; FetchAddr = fa;
  endtask

  task automatic beat(input logic [W-1:0] d, input bit last);
    repeat ($urandom_range(2)) cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 1, last, d, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    // Reset held for 3 cycles with a fetch of address 0 pending, then an IDLE fetch.
    FetchReq = 1'b1;
    FetchAddr = 3'd0;
    #1 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    idle(2);

    // Full image without LoadLast: u0 takes 6 beats, u1 stops after 4.
    cyc(1, 0, 0, '0, 0, 0);
    for (int k = 0; k < 6; k++) beat(W'($urandom), 0);
    idle(2);
    for (int a = 0; a < 8; a++) cyc(0, 0, 0, '0, 1, 3'(a));
    idle(2);

    // Short image terminated by LoadLast.
    cyc(1, 0, 0, '0, 0, 0);
    beat(9'h001, 0);
    beat(9'h049, 0);
    beat(9'h081, 0);
    beat(9'h1FF, 1);
    idle(2);
    for (int a = 0; a < 4; a++) cyc(0, 0, 0, '0, 1, 3'(a));
    cyc(0, 0, 0, '0, 1, 3'd5);
    cyc(0, 0, 0, '0, 1, 3'd6);
    cyc(0, 0, 0, '0, 1, 3'd7);
    idle(2);

    // Reload colliding with a fetch, then a restart mid-load with a beat that must be dropped.
    cyc(1, 0, 0, '0, 1, 3'd1);
    beat(W'($urandom), 0);
    beat(W'($urandom), 0);
    cyc(1, 1, 0, 9'h0AA, 0, 0);
    beat(W'($urandom), 0);
    beat(W'($urandom), 0);
    beat(W'($urandom), 1);
    idle(1);
    for (int a = 0; a < 3; a++) cyc(0, 0, 0, '0, 1, 3'(a));
    idle(1);

    // Asynchronous reset between edges in the middle of a load.
    cyc(1, 0, 0, '0, 0, 0);
    beat(W'($urandom), 0);
    beat(W'($urandom), 0);
    idle(1);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    FetchReq = 1'b1;
    FetchAddr = 3'd0;
    idle(2);

    // Randomised mix of loads, restarts and fetches.
    for (int c = 0; c < 250; c++) begin
      cyc(($urandom_range(24) == 0), 1'($urandom), ($urandom_range(4) == 0), W'($urandom),
          ($urandom_range(2) != 0), 3'($urandom));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised instruction memory for the fetch stage; successor to the fixed, combinational instruction ROM.
- Adds a streaming program-load port, so the testbench or a boot controller can write a program image at run time.
- Fetch uses a synchronous read with one-cycle latency, plus a valid/error indication.
- Sits between the program counter/fetch logic and the decoder; the load port faces the boot/test harness.

Parameters:
A, 10, fetch address width in bits
W, 9, instruction word width in bits
DEPTH, 2**A, number of implemented words; must satisfy DEPTH <= 2**A
HALT_WORD, all ones (W bits), word returned on any invalid fetch; decodes as halt

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
LoadStart  in  1  single-cycle pulse: begin a new image load at address 0
LoadValid  in  1  load beat valid
LoadData  in  W  load beat instruction word
LoadLast  in  1  marks the final beat of the image
LoadReady  out  1  memory accepts load beats
LoadDone  out  1  single-cycle pulse when a load completes
Loaded  out  1  a complete image is present
LoadCount  out  A+1  words written by the current or most recent load
FetchReq  in  1  fetch request
FetchAddr  in  A  fetch word address
FetchValid  out  1  InstOut/FetchErr carry a fetch response this cycle
InstOut  out  W  fetched instruction
FetchErr  out  1  response is invalid; InstOut = HALT_WORD

Behaviour:
- Reset: asynchronous, active-low. While Reset_n is low:
  - state=IDLE; LoadReady=0, LoadDone=0, Loaded=0, LoadCount=0.
  - FetchValid=0, FetchErr=0, InstOut=HALT_WORD.
  - Memory array is not cleared.
- Reset asserted mid-load aborts the load; Loaded stays 0 until a new load completes.
- States: IDLE, LOAD, RUN.
- IDLE:
  - LoadStart -> LOAD; write pointer=0; LoadCount=0.
- LOAD:
  - LoadReady=1.
  - A beat is LoadValid&LoadReady: mem[ptr]<=LoadData; ptr++; LoadCount++.
  - Beat with LoadLast=1, or beat at ptr==DEPTH-1 -> RUN. LoadDone pulses for exactly one cycle after that beat's edge; Loaded=1 from the same cycle.
  - A beat at ptr==DEPTH-1 without LoadLast still terminates the load; LoadCount=DEPTH. Extra beats are not accepted because LoadReady=0 in RUN.
  - LoadStart in LOAD restarts: ptr=0, LoadCount=0, and any beat presented in the same cycle is discarded.
- RUN:
  - LoadReady=0.
  - LoadStart -> LOAD; Loaded drops to 0 on the next edge; ptr=0; LoadCount=0.
- Fetch, all states, latency 1:
  - FetchReq sampled at edge N gives FetchValid=1 during cycle N+1. FetchReq is accepted every cycle, with no back-pressure.
  - Valid response requires: state RUN, no LoadStart in the same cycle, and FetchAddr < DEPTH. Then InstOut=mem[FetchAddr] and FetchErr=0.
  - Otherwise InstOut=HALT_WORD and FetchErr=1. This covers IDLE, LOAD, address >= DEPTH, and a simultaneous LoadStart.
  - A fetch at address k is valid even when k >= LoadCount; it returns the stale array contents. This is deliberate, since the image length is software-defined.
  - Without FetchReq: FetchValid=0, FetchErr=0, InstOut holds its last value.
- Read/write hazard: not possible, because writes occur only in LOAD and valid reads only in RUN.
- LoadCount saturates at DEPTH (width A+1, so DEPTH=2**A fits).

Optional Feature:
- Macro: INST_MEM_CHECKSUM_EN.
- With the macro defined:
  - Extra output LoadSum (W bits): modulo-2**W sum of all LoadData beats accepted in the current/most recent load.
  - Cleared to 0 on reset and on every accepted LoadStart. Valid and stable once LoadDone has pulsed.
- Without the macro: no LoadSum port, no accumulator logic.

Test Plan:
- Reset then fetch: Reset_n low 3 cycles, FetchReq=1 addr 0 in IDLE -> next cycle FetchValid=1, FetchErr=1, InstOut=9'h1FF; Loaded=0.
- Load 4 words 0x001,0x049,0x081,0x1FF (LoadLast on 4th), LoadValid toggled with gaps -> LoadDone one pulse, Loaded=1, LoadCount=4; fetch addrs 0..3 back-to-back -> InstOut matches, FetchErr=0, one word per cycle at 1-cycle latency; with INST_MEM_CHECKSUM_EN, LoadSum=0x0CA (0x2CA mod 512).
- Overflow, A=2: load 6 beats with no LoadLast -> only 4 accepted, LoadReady=0 after the 4th, LoadCount=4, LoadDone pulses after the 4th beat.
- Out-of-range, DEPTH=6, A=3: after load, fetch addr 6 and 7 -> InstOut=HALT_WORD, FetchErr=1; addr 5 returns the stored word.
- Reload/collision in RUN: LoadStart together with FetchReq addr 1 -> response FetchErr=1, HALT_WORD; Loaded=0 next cycle; a second LoadStart mid-load after 2 beats restarts, LoadCount=0.
- Async reset mid-load: drop Reset_n between edges after 2 beats -> outputs reset immediately without a clock edge; state IDLE; fetch returns FetchErr=1.
